// File: rtl/gfau_arbiter_if.sv
// Buses around the GFAU arbiter: requester side (master = requesters) and
// GFAU side (master = arbiter driving the shared field unit).
interface gfau_req_if #(
  parameter int NREQ = 4,
  parameter int W    = 32
);
  logic [NREQ-1:0]   req_valid;
  logic [2*NREQ-1:0] req_op;
  logic [W*NREQ-1:0] req_a;
  logic [W*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_result;
  logic              rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready, rsp_valid, rsp_result, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready, rsp_valid, rsp_result, rsp_err
  );
endinterface

interface gfau_core_if #(
  parameter int W = 32
);
  logic [W-1:0] gf_in_0;
  logic [W-1:0] gf_in_1;
  logic [W-1:0] gf_prime;
  logic [1:0]   gf_op;
  logic         gf_dfc;
  logic [W-1:0] gf_result;
  logic         gf_done;

  modport master (
    output gf_in_0, gf_in_1, gf_prime, gf_op, gf_dfc,
    input  gf_result, gf_done
  );

  modport slave (
    input  gf_in_0, gf_in_1, gf_prime, gf_op, gf_dfc,
    output gf_result, gf_done
  );
endinterface

// File: rtl/gfau_arbiter.sv
// Round-robin arbiter sharing one GFAU between NREQ requesters, with a shared
// prime register, a divide-by-zero guard and a watchdog on GFAU completion.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | pick a winner (or load the prime); GFAU inputs held at 0
//   ST_WAIT | operands on the GFAU, watchdog counting, waiting for done
//   ST_ACK  | one-cycle response to the winner, done_from_control pulse
module gfau_arbiter #(
  parameter int           NREQ      = 4,
  parameter int           W         = 32,
  parameter int           TIMEOUT   = 256,
  parameter logic [W-1:0] PRIME_RST = W'(32'h0000_0061)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  gfau_req_if.slave    req,
  gfau_core_if.master  gf,
  input  logic         prime_load,
  input  logic [W-1:0] prime_in,
  output logic         busy,
  output logic         timeout_flag
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] win_idx;
  logic          win_found;
  logic [PW:0]   cand;

  logic [1:0]    sel_op;
  logic [W-1:0]  sel_a;
  logic [W-1:0]  sel_b;
  logic          div_zero;
  logic          accept;

  logic [1:0]    op_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  result_q;
  logic [W-1:0]  prime_q;
  logic          err_q;
  logic          dz_q;
  logic [CW-1:0] wd_cnt;
  logic          wd_hit;
  logic          timeout_q;

  // Scan from the round-robin pointer upward, wrapping at NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(i);
      if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
      if (!win_found && req.req_valid[cand[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
  end

  assign sel_op   = req.req_op[2*int'(win_idx) +: 2];
  assign sel_a    = req.req_a[W*int'(win_idx) +: W];
  assign sel_b    = req.req_b[W*int'(win_idx) +: W];
  assign div_zero = (sel_op == 2'd3) && (sel_b == '0);
  assign accept   = (state == ST_IDLE) && !i_rst && !prime_load && win_found;
  assign wd_hit   = (wd_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = div_zero ? ST_ACK : ST_WAIT;
      ST_WAIT: if (gf.gf_done || wd_hit) state_nxt = ST_ACK;
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr    <= '0;
      gnt_idx   <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
      dz_q      <= 1'b0;
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
      prime_q   <= PRIME_RST;
    end else begin
      case (state)
        ST_IDLE: begin
          if (prime_load) begin
            prime_q <= prime_in;
          end else if (accept) begin
            gnt_idx  <= win_idx;
            op_q     <= sel_op;
            a_q      <= sel_a;
            b_q      <= sel_b;
            dz_q     <= div_zero;
            err_q    <= div_zero;
            result_q <= '0;
            wd_cnt   <= '0;
          end
        end
        ST_WAIT: begin
          wd_cnt <= wd_cnt + 1'b1;
          // A done coinciding with the last watchdog cycle still counts as success.
          if (gf.gf_done) begin
            result_q <= gf.gf_result;
          end else if (wd_hit) begin
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        ST_ACK: begin
          rr_ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          wd_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req.req_ready  = '0;
    req.rsp_valid  = '0;
    req.rsp_result = '0;
    req.rsp_err    = 1'b0;
    gf.gf_in_0     = '0;
    gf.gf_in_1     = '0;
    gf.gf_op       = '0;
    gf.gf_dfc      = 1'b0;
    if (accept) req.req_ready = NREQ'(1) << win_idx;
    case (state)
      ST_WAIT: begin
        gf.gf_in_0 = a_q;
        gf.gf_in_1 = b_q;
        gf.gf_op   = op_q;
      end
      ST_ACK: begin
        req.rsp_valid  = NREQ'(1) << gnt_idx;
        req.rsp_result = err_q ? '0 : result_q;
        req.rsp_err    = err_q;
        // A divide-by-zero reject never engaged the GFAU, so nothing to acknowledge.
        gf.gf_dfc      = !dz_q;
      end
      default: ;
    endcase
  end

  assign gf.gf_prime    = prime_q;
  assign busy           = (state != ST_IDLE);
  assign timeout_flag   = timeout_q;
endmodule

// File: doc/gfau_arbiter.md
Name: gfau_arbiter

Overview:
- Shares one GFAU instance between NREQ requesters, such as point-add and point-double sequencers.
- Each requester submits an (op, a, b) transaction. The arbiter picks one round-robin, holds the operands on the GFAU inputs until the GFAU reports done, acknowledges the GFAU through done_from_control, and returns the result to the winner.
- Holds the shared prime register, guards against divide-by-zero, and guards against a hung GFAU with a watchdog.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 32, operand/result width; matches the GFAU datapath.
- TIMEOUT, 256, maximum cycles in WAIT before the watchdog aborts.
- PRIME_RST, 32'h0000_0061, reset value of the prime register.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester transaction valid.
- req_op  in  2*NREQ  per-requester op: 0 add, 1 sub, 2 mult, 3 div (slice k = bits 2k+1:2k).
- req_a  in  W*NREQ  per-requester operand a.
- req_b  in  W*NREQ  per-requester operand b.
- req_ready  out  NREQ  one-hot accept; transfer when req_valid[k]&req_ready[k] at a rising edge.
- rsp_valid  out  NREQ  one-hot, 1-cycle response strobe to the granted requester.
- rsp_result  out  W  result; valid only while any rsp_valid bit is high.
- rsp_err  out  1  qualifies rsp_valid: 1 = div-by-zero or timeout, and rsp_result = 0.
- prime_load  in  1  load prime_in into the prime register.
- prime_in  in  W  new prime value.
- gf_in_0, gf_in_1  out  W  to GFAU in_0/in_1.
- gf_prime  out  W  to GFAU prime; always equals the prime register.
- gf_op  out  2  to GFAU operation_select.
- gf_dfc  out  1  to GFAU done_from_control.
- gf_result  in  W  from GFAU result.
- gf_done  in  1  from GFAU done_to_control.
- busy  out  1  high in any state other than IDLE.
- timeout_flag  out  1  sticky; set on a watchdog abort, cleared only by reset.

Behaviour:
- Reset (i_rst=1 at an edge, in any state, including mid-transaction):
  - state=IDLE, rr pointer=0, prime reg=PRIME_RST, watchdog counter=0.
  - All outputs 0 except gf_prime=PRIME_RST.
  - In-flight transaction is dropped; no rsp_valid is issued for it.
- GFAU handshake: operands and op are held stable from the issue cycle until gf_dfc. gf_dfc is a 1-cycle pulse after gf_done is sampled high; the GFAU clears done after gf_dfc.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - prime_load=1 has priority: prime reg<=prime_in, req_ready=0, stay IDLE.
  - Otherwise the winner is the first k with req_valid[k]=1, scanning from rr pointer upward with wrap-around. req_ready[winner]=1 combinationally that cycle; all other bits are 0.
  - At the edge: latch gnt, op, a, b.
  - If op=3 and b=0: go to ACK with the error path; the GFAU is never driven and gf_dfc stays 0.
  - Otherwise go to WAIT.
- prime_load outside IDLE is ignored; the prime never changes while an operation is in flight.
- WAIT:
  - gf_in_0=a, gf_in_1=b, gf_op=op; these are 0 in IDLE.
  - Counter increments each cycle.
  - gf_done=1 at an edge: latch gf_result, go to ACK.
  - Counter==TIMEOUT-1 with gf_done=0: go to ACK with the error path and set timeout_flag.
  - gf_done has priority if it coincides with the timeout cycle.
- ACK (exactly 1 cycle):
  - rsp_valid[gnt]=1, rsp_result=latched result (0 on error), rsp_err as applicable.
  - gf_dfc=1 unless this is a div-by-zero reject.
  - rr pointer<=(gnt+1) mod NREQ; counter<=0; go to IDLE.
- Latency:
  - Accept edge T; WAIT starts in cycle T+1.
  - If gf_done is sampled at edge T+1+L, rsp_valid is in the following cycle.
  - Minimum accept-to-rsp is 2 cycles.
  - One mandatory IDLE cycle separates consecutive transactions.
- req_valid dropping after accept has no effect. A requester's req_valid held through its own rsp is treated as a new request in the next IDLE.
- gf_result is only sampled in WAIT; gf_done outside WAIT is ignored.

Test Plan:
- Bench: behavioural GFAU model with programmable latency; prime=97.
  - Single requester 0, add a=50, b=60, GFAU latency 3:
    - req_ready[0] in the accept cycle.
    - rsp_valid[0] with rsp_result=13, rsp_err=0.
    - gf_dfc is 1 cycle, in the same cycle as rsp_valid.
  - All 4 requesters valid simultaneously, mult 3*5, latency 1:
    - Grants in order 0,1,2,3, each rsp_result=15.
    - Then requester 1 alone next: granted immediately.
    - Pointer wraps 3->0.
- prime_load=1 with prime_in=101 and req_valid[2]=1 in the same IDLE cycle: no grant that cycle, prime reg=101, requester 2 granted the next cycle, sub 5-10 returns 96.
- Div a=7, b=0:
  - rsp_err=1, rsp_result=0, gf_dfc never asserted.
  - Pipeline: IDLE, ACK, then back to IDLE in 2 cycles.
  - timeout_flag stays 0.
- GFAU never asserts done, TIMEOUT=256:
  - rsp_err=1 exactly 257 cycles after accept.
  - timeout_flag=1, sticky through later successful ops, cleared by i_rst.
- i_rst pulsed during WAIT of a div:
  - Next cycle busy=0, all gf_* outputs 0, gf_prime=0x61.
  - No rsp_valid issued; a late gf_done is ignored.
